// File: rtl/mac_accumulator_pkg.sv
// Shared MAC definitions: datapath widths and the accumulator FSM encoding,
// exported so the MAC controller can decode the busy phases.
package mac_accumulator_pkg;

    localparam int MACC_DATA_WIDTH = 16;
    localparam int MACC_CNT_WIDTH  = 6;

    localparam logic [1:0] MACC_IDLE  = 2'b00;
    localparam logic [1:0] MACC_ACCUM = 2'b01;
    localparam logic [1:0] MACC_DONE  = 2'b10;

    // Run length encoded in a term-count field; zero stands for the full 2^w terms.
    function automatic int macc_run_length(input int field, input int cnt_width);
        return (field == 0) ? (1 << cnt_width) : field;
    endfunction

endpackage

// File: rtl/mac_sat.sv
// Combinational signed saturation from a wide guarded value down to OUT_WIDTH,
// with an indicator that the value had to be clipped.
module mac_sat #(
    parameter int IN_WIDTH  = 22,
    parameter int OUT_WIDTH = 16
) (
    input  logic [IN_WIDTH-1:0]  din,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 clip
);

    localparam int GUARD = IN_WIDTH - OUT_WIDTH + 1;

    logic                  sign;
    logic [GUARD-1:0]      guard_diff;
    logic [OUT_WIDTH-1:0]  pos_max;
    logic [OUT_WIDTH-1:0]  neg_min;

    assign sign    = din[IN_WIDTH-1];
    assign pos_max = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    assign neg_min = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // The value fits only if every bit from the output MSB upward equals the sign.
    genvar gi;
    generate
        for (gi = 0; gi < GUARD; gi++) begin : g_guard
            assign guard_diff[gi] = din[OUT_WIDTH-1+gi] ^ sign;
        end
    endgenerate

    assign clip = |guard_diff;

    always_comb begin
        dout = din[OUT_WIDTH-1:0];
        if (clip) begin
            dout = sign ? neg_min : pos_max;
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulate stage behind the MAC multiplier: sums a programmed number of
// Q2.14 products in a guarded register and emits the saturated result.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = MACC_DATA_WIDTH,
    parameter int CNT_WIDTH  = MACC_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_terms,
    input  logic                  prod_valid,
    input  logic [DATA_WIDTH-1:0] prod_in,
    output logic                  prod_ready,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] acc_out,
    output logic                  acc_valid,
    output logic                  sat_flag
);

    localparam int ACC_WIDTH = DATA_WIDTH + CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]            state_reg, state_next;
    logic [CNT_WIDTH-1:0]  num_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;
    logic [CNT_WIDTH-1:0]  cnt_last;
    logic [ACC_WIDTH-1:0]  acc_reg;
    logic [ACC_WIDTH-1:0]  acc_sum;
    logic [ACC_WIDTH-1:0]  prod_ext;
    logic [DATA_WIDTH-1:0] acc_out_reg;
    logic                  acc_valid_reg;
    logic                  sat_flag_reg;
    logic                  handshake;
    logic                  last_term;
    logic [DATA_WIDTH-1:0] sat_dout;
    logic                  sat_clip;

    assign handshake = prod_valid && (state_reg == MACC_ACCUM);
    // A zero count wraps to all-ones here, which is exactly the 2^CNT_WIDTH case.
    assign cnt_last  = num_reg - CNT_ONE;
    assign last_term = handshake && (cnt_reg == cnt_last);
    assign prod_ext  = {{CNT_WIDTH{prod_in[DATA_WIDTH-1]}}, prod_in};
    assign acc_sum   = acc_reg + prod_ext;

    // Saturate the sum including the current product so the result is ready
    // in the same cycle the FSM enters DONE.
    mac_sat #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (DATA_WIDTH)
    ) u_sat (
        .din  (acc_sum),
        .dout (sat_dout),
        .clip (sat_clip)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MACC_IDLE:  if (start) state_next = MACC_ACCUM;
            MACC_ACCUM: if (last_term) state_next = MACC_DONE;
            MACC_DONE:  state_next = MACC_IDLE;
            default:    state_next = MACC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= MACC_IDLE;
            num_reg       <= '0;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            acc_out_reg   <= '0;
            acc_valid_reg <= 1'b0;
            sat_flag_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_valid_reg <= 1'b0;
            case (state_reg)
                MACC_IDLE: begin
                    if (start) begin
                        num_reg      <= num_terms;
                        cnt_reg      <= '0;
                        acc_reg      <= '0;
                        sat_flag_reg <= 1'b0;
                    end
                end
                MACC_ACCUM: begin
                    if (handshake) begin
                        acc_reg <= acc_sum;
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                    if (last_term) begin
                        acc_out_reg   <= sat_dout;
                        sat_flag_reg  <= sat_clip;
                        acc_valid_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign prod_ready = (state_reg == MACC_ACCUM);
    assign busy       = (state_reg == MACC_ACCUM) || (state_reg == MACC_DONE);
    assign acc_out    = acc_out_reg;
    assign acc_valid  = acc_valid_reg;
    assign sat_flag   = sat_flag_reg;

endmodule
